// File: rtl/alarm_unit.sv
// alarm_unit: programmable alarm with snooze and ring timeout, fed by the time-of-day counter.
module alarm_unit #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic [9:0] msec_i,
    input  logic       arm_i,
    input  logic       set_i,
    input  logic [4:0] alarm_hour_i,
    input  logic [5:0] alarm_min_i,
    input  logic       stop_i,
    input  logic       snooze_i,
    output logic       ring_o,
    output logic [1:0] state_o,
    output logic [4:0] target_hour_o,
    output logic [5:0] target_min_o
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;
    logic [1:0] state, nxt_state;
    logic [4:0] base_h, tgt_h, nxt_base_h, nxt_tgt_h, snz_h;
    logic [5:0] base_m, tgt_m, nxt_base_m, nxt_tgt_m, snz_m, sec_q;
    logic [7:0] ring_cnt, nxt_cnt;
    logic [6:0] snz_sum;
    logic       match, match_q, trigger, tick, load_ok, timeout, wrap;
    assign match   = hour_i == tgt_h && min_i == tgt_m && sec_i == 6'd0 && msec_i == 10'd0;
    assign trigger = match && !match_q && arm_i;
    assign tick    = sec_i != sec_q;
    assign load_ok = set_i && alarm_hour_i <= 5'd23 && alarm_min_i <= 6'd59;
    assign timeout = tick && ring_cnt == 8'(RING_SEC - 1);
    // snooze add: 7-bit minute sum, one conditional subtract, hour wraps at 24
    assign snz_sum = {1'b0, tgt_m} + 7'(SNOOZE_MIN);
    assign wrap    = snz_sum >= 7'd60;
    assign snz_m   = 6'(wrap ? snz_sum - 7'd60 : snz_sum);
    assign snz_h   = !wrap ? tgt_h : (tgt_h == 5'd23 ? 5'd0 : tgt_h + 5'd1);
    always_comb begin
        nxt_state  = state;
        nxt_base_h = base_h;
        nxt_base_m = base_m;
        nxt_tgt_h  = tgt_h;
        nxt_tgt_m  = tgt_m;
        nxt_cnt    = ring_cnt;
        if (!arm_i) begin
            nxt_state = IDLE;
            nxt_tgt_h = base_h;
            nxt_tgt_m = base_m;
        end else if (load_ok) begin
            nxt_state  = IDLE;
            nxt_base_h = alarm_hour_i;
            nxt_base_m = alarm_min_i;
            nxt_tgt_h  = alarm_hour_i;
            nxt_tgt_m  = alarm_min_i;
        end else if (stop_i && state != IDLE) begin
            nxt_state = IDLE;
            nxt_tgt_h = base_h;
            nxt_tgt_m = base_m;
        end else if (snooze_i && state == RINGING) begin
            nxt_state = SNOOZE;
            nxt_tgt_h = snz_h;
            nxt_tgt_m = snz_m;
        end else if (state == RINGING && timeout) begin
            nxt_state = IDLE;
            nxt_tgt_h = base_h;
            nxt_tgt_m = base_m;
        end else if (state == RINGING && tick) begin
            nxt_cnt = ring_cnt + 8'd1;
        end else if (state != RINGING && trigger) begin
            nxt_state = RINGING;
            nxt_cnt   = 8'd0;
        end
    end
    // match_q resets high so leaving reset at 00:00:00.000 is not seen as a new match
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            ring_o   <= 1'b0;
            base_h   <= 5'd0;
            base_m   <= 6'd0;
            tgt_h    <= 5'd0;
            tgt_m    <= 6'd0;
            ring_cnt <= 8'd0;
            sec_q    <= 6'd0;
            match_q  <= 1'b1;
        end else begin
            state    <= nxt_state;
            ring_o   <= nxt_state == RINGING;
            base_h   <= nxt_base_h;
            base_m   <= nxt_base_m;
            tgt_h    <= nxt_tgt_h;
            tgt_m    <= nxt_tgt_m;
            ring_cnt <= nxt_cnt;
            sec_q    <= sec_i;
            match_q  <= match;
        end
    end
    assign state_o       = state;
    assign target_hour_o = tgt_h;
    assign target_min_o  = tgt_m;
endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed plus random stimulus scored against a minutes-of-day reference model.
module tb_alarm_unit;
    localparam int RING_SEC   = 60;
    localparam int SNOOZE_MIN = 5;
    localparam int DAY_MS     = 86_400_000;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] hour_i = '0;
    logic [5:0] min_i = '0;
    logic [5:0] sec_i = '0;
    logic [9:0] msec_i = '0;
    logic       arm_i = 1'b1;
    logic       set_i = 1'b0;
    logic [4:0] alarm_hour_i = '0;
    logic [5:0] alarm_min_i = '0;
    logic       stop_i = 1'b0;
    logic       snooze_i = 1'b0;
    logic       ring_o;
    logic [1:0] state_o;
    logic [4:0] target_hour_o;
    logic [5:0] target_min_o;
    alarm_unit #(.RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)) dut (
        .clk_i(clk), .rst_i(rst_i), .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i),
        .msec_i(msec_i), .arm_i(arm_i), .set_i(set_i), .alarm_hour_i(alarm_hour_i),
        .alarm_min_i(alarm_min_i), .stop_i(stop_i), .snooze_i(snooze_i), .ring_o(ring_o),
        .state_o(state_o), .target_hour_o(target_hour_o), .target_min_o(target_min_o)
    );
    always #5 clk = ~clk;
    int vecs = 0;
    int errs = 0;
    int tod = 0;
    logic [13:0] exp_q[$];
    // reference model: times kept as minutes of the day, state as 0/1/2
    int m_st = 0, m_base = 0, m_tgt = 0, m_sq = 0, m_ticks = 0;
    bit m_mq = 1'b1;
    task automatic set_tod(input int t);
        tod = ((t % DAY_MS) + DAY_MS) % DAY_MS;
        hour_i = 5'(tod / 3_600_000);
        min_i  = 6'((tod / 60_000) % 60);
        sec_i  = 6'((tod / 1000) % 60);
        msec_i = 10'(tod % 1000);
    endtask
    task automatic model_step();
        bit match, tick, trig;
        logic [13:0] e;
        if (!rst_i) begin
            m_st = 0; m_base = 0; m_tgt = 0; m_sq = 0; m_ticks = 0; m_mq = 1'b1;
        end else begin
            match = (int'(hour_i) * 60 + int'(min_i) == m_tgt) && sec_i == 0 && msec_i == 0;
            tick  = int'(sec_i) != m_sq;
            trig  = match && !m_mq && arm_i;
            if (!arm_i) begin
                m_st = 0; m_tgt = m_base;
            end else if (set_i && alarm_hour_i < 24 && alarm_min_i < 60) begin
                m_st = 0; m_base = int'(alarm_hour_i) * 60 + int'(alarm_min_i); m_tgt = m_base;
            end else if (stop_i && m_st != 0) begin
                m_st = 0; m_tgt = m_base;
            end else if (snooze_i && m_st == 1) begin
                m_st = 2; m_tgt = (m_tgt + SNOOZE_MIN) % 1440;
            end else if (m_st == 1 && tick) begin
                m_ticks++;
                if (m_ticks == RING_SEC) begin
                    m_st = 0; m_tgt = m_base;
                end
            end else if (m_st != 1 && trig) begin
                m_st = 1; m_ticks = 0;
            end
            m_mq = match;
            m_sq = int'(sec_i);
        end
        e = {m_st == 1, 2'(m_st), 5'(m_tgt / 60), 6'(m_tgt % 60)};
        exp_q.push_back(e);
    endtask
    task automatic go(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
            #1;
        end
    endtask
    task automatic pulse_set(input int h, input int m);
        set_i = 1'b1; alarm_hour_i = 5'(h); alarm_min_i = 6'(m);
        go();
        set_i = 1'b0;
    endtask
    task automatic ring_at(input int t_min);
        set_tod(t_min * 60_000 - 1);
        go();
        set_tod(t_min * 60_000);
        go(2);
    endtask
    always @(negedge clk) begin
        logic [13:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vecs++;
            if ({ring_o, state_o, target_hour_o, target_min_o} !== e) begin
                errs++;
                $display("FAIL vec%0d t=%0t: ring/state/tgt got %b/%0d/%0d:%0d want %b/%0d/%0d:%0d",
                    vecs, $time, ring_o, state_o, target_hour_o, target_min_o,
                    e[13], e[12:11], e[10:6], e[5:0]);
            end
        end
    end
    initial begin
        int r;
        @(negedge clk);
        #1;
        // reset released at 00:00:00.000 while armed must not ring
        set_tod(0);
        go(2);
        rst_i = 1'b1;
        go(5);
        // basic ring and timeout
        pulse_set(6, 30);
        ring_at(6 * 60 + 30);
        for (int i = 1; i <= RING_SEC + 2; i++) begin
            set_tod((6 * 60 + 30) * 60_000 + i * 1000);
            go(2);
        end
        // snooze wrapping past midnight, ring again, stop restores base
        pulse_set(23, 58);
        ring_at(23 * 60 + 58);
        snooze_i = 1'b1; go(); snooze_i = 1'b0;
        go(2);
        ring_at(3);
        stop_i = 1'b1; go(); stop_i = 1'b0;
        go(2);
        // no retrigger after stop inside the msec==0 window
        pulse_set(6, 30);
        set_tod((6 * 60 + 30) * 60_000 - 1);
        go();
        set_tod((6 * 60 + 30) * 60_000);
        go();
        stop_i = 1'b1; go(); stop_i = 1'b0;
        go(10);
        // priority cases
        ring_at(6 * 60 + 30);
        stop_i = 1'b1; snooze_i = 1'b1; go(); stop_i = 1'b0; snooze_i = 1'b0;
        ring_at(6 * 60 + 30);
        pulse_set(7, 0);
        go();
        ring_at(7 * 60);
        snooze_i = 1'b1; go(); snooze_i = 1'b0;
        arm_i = 1'b0; go(); arm_i = 1'b1;
        go();
        // invalid loads leave base and target alone
        pulse_set(24, 10);
        pulse_set(5, 60);
        pulse_set(31, 63);
        go();
        // asynchronous reset while ringing
        ring_at(7 * 60);
        rst_i = 1'b0;
        #1;
        vecs++;
        if ({ring_o, state_o, target_hour_o, target_min_o} !== 14'd0) begin
            errs++;
            $display("FAIL async_reset: ring/state/tgt got %b/%0d/%0d:%0d want 0/0/0:0",
                ring_o, state_o, target_hour_o, target_min_o);
        end
        go(2);
        rst_i = 1'b1;
        go(3);
        // randomized traffic
        pulse_set(12, 0);
        for (int c = 0; c < 6000; c++) begin
            arm_i    = ($urandom % 40) != 0;
            stop_i   = ($urandom % 40) == 0;
            snooze_i = ($urandom % 20) == 0;
            set_i    = ($urandom % 60) == 0;
            alarm_hour_i = 5'($urandom_range(0, 25));
            alarm_min_i  = 6'($urandom_range(0, 61));
            rst_i    = ($urandom % 1500) != 0;
            r = int'($urandom % 16);
            if (r < 2) set_tod(m_tgt * 60_000);
            else if (r == 2) set_tod(m_base * 60_000);
            else if (r < 7) set_tod((tod / 1000 + 1) * 1000);
            else if (r == 7) set_tod(int'($urandom_range(0, 1439)) * 60_000);
            else set_tod(tod + 1);
            go();
        end
        arm_i = 1'b1; stop_i = 1'b0; snooze_i = 1'b0; set_i = 1'b0; rst_i = 1'b1;
        go(2);
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain: queue holds %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
